egress_output_ctrl: RTL

- Output-control stage directly downstream of the egress offset stage; consumes its 134-bit flit stream plus its per-packet keep/discard verdict.
- Buffers flits and verdicts in two FIFOs. Forwards kept packets to the port side under backpressure and silently drains discarded ones.
- Presents a packet-granular almost-full to the upstream stage.

---
 rtl/egress_output_ctrl_pkg.sv | 30 +++
 rtl/egress_output_ctrl_fifo.sv | 54 +++++
 rtl/egress_output_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/egress_output_ctrl_pkg.sv
// Shared definitions for the egress output-control stage:
// flit layout, flit-type codes and the forwarding FSM states.
package egress_output_ctrl_pkg;

  localparam int FLIT_W  = 134;
  localparam int TYPE_HI = 133;
  localparam int TYPE_LO = 132;
  localparam int INV_HI  = 131;
  localparam int INV_LO  = 128;
  localparam int DATA_HI = 127;
  localparam int DATA_LO = 0;

  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_MID  = 2'b11;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLAG,
    ST_FWD,
    ST_DROP
  } state_t;

  function automatic logic is_tail(
    input logic [FLIT_W-1:0] f
  );
    return f[TYPE_HI:TYPE_LO] == FLIT_TAIL;
  endfunction

endpackage

// File: rtl/egress_output_ctrl_fifo.sv
// Synchronous FIFO with registered read data (one-cycle latency).
// Writes to a full FIFO and reads of an empty FIFO are ignored.
module egress_sync_fifo #(
  parameter int WIDTH = 134,
  parameter int DEPTH = 256,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = count == '0;
  assign full  = count == (AW+1)'(DEPTH);
  assign wr_en = wr & ~full;
  assign rd_en = rd & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/egress_output_ctrl.sv
// Egress output control: buffers flits and verdicts, forwards kept packets.
// Define EGRESS_OUTCTRL_STATS_EN for forwarded/dropped packet counters.
module egress_output_ctrl
  import egress_output_ctrl_pkg::*;
#(
  parameter int DATA_DEPTH  = 256,
  parameter int VALID_DEPTH = 64,
  parameter int DATA_AFULL  = 160,
  parameter int VALID_AFULL = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_egress_pkt_wr,
  input  logic [FLIT_W-1:0] in_egress_pkt,
  input  logic              in_egress_valid_wr,
  input  logic              in_egress_valid,
  output logic              out_egress_pkt_almostfull,
  output logic              out_port_pkt_wr,
  output logic [FLIT_W-1:0] out_port_pkt,
  output logic              out_port_valid_wr,
  output logic              out_port_valid,
  input  logic              in_port_pkt_almostfull
`ifdef EGRESS_OUTCTRL_STATS_EN
  ,
  output logic [31:0]       out_fwd_pkt_cnt,
  output logic [31:0]       out_drop_pkt_cnt
`endif
);

  localparam int DAW = $clog2(DATA_DEPTH);
  localparam int VAW = $clog2(VALID_DEPTH);

  logic              d_rd, d_empty, d_full;
  logic [FLIT_W-1:0] d_dout;
  logic [DAW:0]      d_count;
  logic              v_rd, v_empty, v_full, v_dout;
  logic [VAW:0]      v_count;

  state_t state, state_cur, state_nxt;
  logic   fwd_q, drop_q, afull_q;
  logic   pkt_tail, tail_seen;

  egress_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(DATA_DEPTH)) u_data (
    .clk   (clk),
    .reset (reset),
    .wr    (in_egress_pkt_wr),
    .din   (in_egress_pkt),
    .rd    (d_rd),
    .dout  (d_dout),
    .empty (d_empty),
    .full  (d_full),
    .count (d_count)
  );

  egress_sync_fifo #(.WIDTH(1), .DEPTH(VALID_DEPTH)) u_valid (
    .clk   (clk),
    .reset (reset),
    .wr    (in_egress_valid_wr),
    .din   (in_egress_valid),
    .rd    (v_rd),
    .dout  (v_dout),
    .empty (v_empty),
    .full  (v_full),
    .count (v_count)
  );

  // A popped flit is only visible one cycle later; once it shows a
  // tail, this cycle already behaves as IDLE so no extra flit is taken.
  assign pkt_tail  = is_tail(d_dout);
  assign tail_seen = (fwd_q | drop_q) & pkt_tail;
  assign state_cur = tail_seen ? ST_IDLE : state;

  always_comb begin
    state_nxt = state_cur;
    d_rd      = 1'b0;
    v_rd      = 1'b0;
    unique case (state_cur)
      ST_IDLE: begin
        if (!v_empty) begin
          v_rd      = 1'b1;
          state_nxt = ST_FLAG;
        end
      end
      ST_FLAG: state_nxt = v_dout ? ST_FWD : ST_DROP;
      ST_FWD:  d_rd = !d_empty && !in_port_pkt_almostfull;
      ST_DROP: d_rd = !d_empty;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      fwd_q   <= 1'b0;
      drop_q  <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      fwd_q   <= d_rd & (state_cur == ST_FWD);
      drop_q  <= d_rd & (state_cur == ST_DROP);
      afull_q <= d_full | v_full
               | (d_count >= (DAW+1)'(DATA_AFULL))
               | (v_count >= (VAW+1)'(VALID_AFULL));
    end
  end

  assign out_egress_pkt_almostfull = afull_q;
  assign out_port_pkt_wr           = fwd_q;
  assign out_port_pkt              = d_dout;
  assign out_port_valid_wr         = fwd_q & pkt_tail;
  assign out_port_valid            = fwd_q & pkt_tail;

`ifdef EGRESS_OUTCTRL_STATS_EN
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (fwd_q & pkt_tail)  fwd_cnt  <= fwd_cnt + 32'd1;
      if (drop_q & pkt_tail) drop_cnt <= drop_cnt + 32'd1;
    end
  end

  assign out_fwd_pkt_cnt  = fwd_cnt;
  assign out_drop_pkt_cnt = drop_cnt;
`endif

endmodule
